// File: rtl/msg_buffer_pkg.sv
// Shared constants and helpers for the per-source message buffer.
package msg_buffer_pkg;

   localparam int unsigned NUM_SOURCES = 4;
   localparam logic [7:0]  PREFIX      = 8'hA5;
   localparam int unsigned ADDR_AST    = 3;
   localparam int unsigned MAX_MSG_LEN = 255;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LEN_W  = 8;

   // A message closes on its explicit last byte or when it reaches max_len bytes.
   function automatic logic msg_closes(input logic             last,
                                       input logic [LEN_W-1:0] wcnt,
                                       input int unsigned      max_len);
      return last || ((9'(wcnt) + 9'd1) == 9'(max_len));
   endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: q always presents the entry at the read pointer.
module sync_fifo_sa #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          wrreq,
   input  logic [W-1:0]  wdata,
   input  logic          rdreq,
   output logic [W-1:0]  q,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   usedw
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_wr;
   logic         w_rd;

   assign w_wr = wrreq & ~full;
   assign w_rd = rdreq & ~empty;

   // Pointers carry one extra MSB to tell full from empty.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
   end

   assign q     = r_mem[r_rptr[AW-1:0]];
   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign usedw = r_wptr - r_rptr;

endmodule

// File: rtl/msg_buffer.sv
// Frames a source byte stream into messages and queues them for the command encoder.
module msg_buffer
   import msg_buffer_pkg::*;
#(
   parameter int unsigned DATA_AW = 9,
   parameter int unsigned LEN_AW  = 4,
   parameter int unsigned MAX_LEN = MAX_MSG_LEN
) (
   input  logic               n_rst,
   input  logic               clk,
   input  logic [7:0]         wr_data,
   input  logic               wr_valid,
   input  logic               wr_last,
   output logic               wr_ready,
   output logic               have_msg,
   output logic [7:0]         len,
   output logic [7:0]         data,
   input  logic               rdreq,
   output logic [LEN_AW:0]    msg_count,
   output logic [DATA_AW:0]   bytes_used,
   output logic               trunc_err,
   output logic               rd_err
);

   logic [LEN_W-1:0]  r_wcnt;
   logic [LEN_W-1:0]  r_rcnt;
   logic              r_run;
   logic              r_trunc_err;
   logic              r_rd_err;

   logic [BYTE_W-1:0] w_data_q;
   logic              w_data_empty;
   logic              w_data_full;
   logic [DATA_AW:0]  w_data_usedw;
   logic [LEN_W-1:0]  w_len_q;
   logic              w_len_empty;
   logic              w_len_full;
   logic [LEN_AW:0]   w_len_usedw;

   logic              w_wr_ok;
   logic              w_close;
   logic              w_rd_ok;
   logic              w_rd_last;
   logic [LEN_W-1:0]  w_len_wdata;

   // Length-queue space is required too, so any close can always be pushed.
   assign wr_ready    = r_run & ~w_data_full & ~w_len_full;
   assign have_msg    = ~w_len_empty;
   assign w_wr_ok     = wr_valid & wr_ready;
   assign w_close     = w_wr_ok & msg_closes(wr_last, r_wcnt, MAX_LEN);
   assign w_len_wdata = r_wcnt + 8'd1;
   assign w_rd_ok     = rdreq & have_msg;
   assign w_rd_last   = w_rd_ok & ((9'(r_rcnt) + 9'd1) == {1'b0, w_len_q});

   sync_fifo_sa #(
      .W  (BYTE_W),
      .AW (DATA_AW)
   ) u_data_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .wrreq (w_wr_ok),
      .wdata (wr_data),
      .rdreq (w_rd_ok),
      .q     (w_data_q),
      .empty (w_data_empty),
      .full  (w_data_full),
      .usedw (w_data_usedw)
   );

   sync_fifo_sa #(
      .W  (LEN_W),
      .AW (LEN_AW)
   ) u_len_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .wrreq (w_close),
      .wdata (w_len_wdata),
      .rdreq (w_rd_last),
      .q     (w_len_q),
      .empty (w_len_empty),
      .full  (w_len_full),
      .usedw (w_len_usedw)
   );

   // Framing counters and one-cycle error pulses.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_run       <= 1'b0;
         r_trunc_err <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_run       <= 1'b1;
         r_trunc_err <= w_close & ~wr_last;
         r_rd_err    <= rdreq & ~have_msg;
         if (w_close)      r_wcnt <= '0;
         else if (w_wr_ok) r_wcnt <= r_wcnt + 8'd1;
         if (w_rd_last)    r_rcnt <= '0;
         else if (w_rd_ok) r_rcnt <= r_rcnt + 8'd1;
      end
   end

   // Uninitialised storage is hidden behind the empty flags.
   assign data       = w_data_empty ? 8'h00 : w_data_q;
   assign len        = w_len_empty  ? 8'h00 : w_len_q;
   assign msg_count  = w_len_usedw;
   assign bytes_used = w_data_usedw;
   assign trunc_err  = r_trunc_err;
   assign rd_err     = r_rd_err;

endmodule

// File: tb/tb_msg_buffer.sv
// Randomised and directed bench for msg_buffer with a message-queue reference model.
module tb_msg_buffer;

   localparam int unsigned DATA_AW = 9;
   localparam int unsigned LEN_AW  = 4;
   localparam int DEPTH  = 512;
   localparam int LDEPTH = 16;
   localparam int MAXL   = 255;

   logic               clk = 1'b0;
   logic               n_rst = 1'b1;
   logic [7:0]         wr_data;
   logic               wr_valid;
   logic               wr_last;
   logic               wr_ready;
   logic               have_msg;
   logic [7:0]         len;
   logic [7:0]         data;
   logic               rdreq;
   logic [LEN_AW:0]    msg_count;
   logic [DATA_AW:0]   bytes_used;
   logic               trunc_err;
   logic               rd_err;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // Reference model: stored bytes in order, lengths of closed messages.
   logic [7:0] exp_data[$];
   int         exp_len[$];
   int         open_cnt  = 0;
   int         rd_done   = 0;
   bit         ready_en  = 1'b0;
   bit         exp_trunc = 1'b0;
   bit         exp_rderr = 1'b0;

   msg_buffer #(
      .DATA_AW (DATA_AW),
      .LEN_AW  (LEN_AW),
      .MAX_LEN (MAXL)
   ) dut (
      .n_rst      (n_rst),
      .clk        (clk),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_last    (wr_last),
      .wr_ready   (wr_ready),
      .have_msg   (have_msg),
      .len        (len),
      .data       (data),
      .rdreq      (rdreq),
      .msg_count  (msg_count),
      .bytes_used (bytes_used),
      .trunc_err  (trunc_err),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_data.delete();
      exp_len.delete();
      open_cnt  = 0;
      rd_done   = 0;
      ready_en  = 1'b0;
      exp_trunc = 1'b0;
      exp_rderr = 1'b0;
   endtask

   task automatic check_outputs();
      int nb = exp_data.size();
      int nm = exp_len.size();
      chk("wr_ready",   int'(wr_ready),   int'(ready_en && nb < DEPTH && nm < LDEPTH));
      chk("have_msg",   int'(have_msg),   int'(nm > 0));
      chk("msg_count",  int'(msg_count),  nm);
      chk("bytes_used", int'(bytes_used), nb);
      chk("len",        int'(len),        (nm > 0) ? exp_len[0] : 0);
      chk("data",       int'(data),       (nb > 0) ? int'(exp_data[0]) : 0);
      chk("trunc_err",  int'(trunc_err),  int'(exp_trunc));
      chk("rd_err",     int'(rd_err),     int'(exp_rderr));
   endtask

   // Apply the inputs presented for the coming rising edge to the model.
   task automatic step_model();
      bit rdy  = ready_en && exp_data.size() < DEPTH && exp_len.size() < LDEPTH;
      bit acc  = wr_valid && rdy;
      bit rdok = rdreq && exp_len.size() > 0;
      exp_trunc = 1'b0;
      exp_rderr = rdreq && !rdok;
      if (rdok) begin
         void'(exp_data.pop_front());
         rd_done++;
         if (rd_done == exp_len[0]) begin
            void'(exp_len.pop_front());
            rd_done = 0;
         end
      end
      if (acc) begin
         exp_data.push_back(wr_data);
         open_cnt++;
         if (wr_last || open_cnt == MAXL) begin
            exp_len.push_back(open_cnt);
            exp_trunc = !wr_last;
            open_cnt  = 0;
         end
      end
      ready_en = 1'b1;
   endtask

   // Monitor: compare on the falling edge, then advance the model.
   always @(negedge clk) begin
      if (armed) begin
         if (!n_rst) begin
            model_clear();
            check_outputs();
         end else begin
            check_outputs();
            step_model();
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic put(input logic [7:0] b, input logic l);
      int t = 0;
      wr_valid = 1'b1; wr_data = b; wr_last = l;
      while (!wr_ready && t < 2000) begin @(posedge clk); #1; t++; end
      if (!wr_ready) begin
         checks++; errors++;
         $display("FAIL put_timeout: wr_ready stuck at 0 at %0t", $time);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_last = 1'b0;
   endtask

   task automatic rd();
      rdreq = 1'b1;
      @(posedge clk); #1;
      rdreq = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (have_msg && t < 2000) begin rd(); t++; end
      if (have_msg) begin
         checks++; errors++;
         $display("FAIL drain_timeout: have_msg still 1 at %0t", $time);
      end
   endtask

   initial begin
      wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'h00; rdreq = 1'b0;
      #2 n_rst = 1'b0;
      armed = 1'b1;
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      idle(2);

      // Short message, popped byte by byte
      put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b1);
      idle(1); rd(); rd(); rd(); idle(2);

      // Long message truncated at MAX_LEN, remainder stays open until last
      for (int i = 0; i < 300; i++) put(8'(i), 1'b0);
      idle(2);
      put(8'hEE, 1'b1);
      idle(2); drain();

      // Length queue full after 16 one-byte messages
      for (int i = 0; i < 16; i++) put(8'(i + 1), 1'b1);
      idle(2); rd(); idle(2); drain();

      // Data FIFO full with 200 + 200 + open 112
      for (int i = 0; i < 200; i++) put(8'(i), i == 199);
      for (int i = 0; i < 200; i++) put(8'(i + 7), i == 199);
      for (int i = 0; i < 112; i++) put(8'(i + 3), 1'b0);
      idle(3); rd(); idle(2);
      put(8'h5A, 1'b1);
      drain(); idle(2);

      // Close on the same edge as the final pop of the head message
      put(8'hA1, 1'b1); put(8'hB1, 1'b0);
      wr_valid = 1'b1; wr_data = 8'hB2; wr_last = 1'b1; rdreq = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_last = 1'b0; rdreq = 1'b0;
      idle(2); drain();

      // Reads with nothing queued
      rd(); idle(2); rd(); rd(); idle(2);

      // Reset in the middle of an open message
      put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b0);
      n_rst = 1'b0;
      idle(2);
      n_rst = 1'b1;
      idle(3);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = 8'($urandom);
         wr_last  = ($urandom_range(0, 15) == 0);
         rdreq    = ($urandom_range(0, 2) == 0);
         @(posedge clk); #1;
      end
      wr_valid = 1'b0; wr_last = 1'b0; rdreq = 1'b0;
      idle(2); drain(); idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
